// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch channel between the IFU (master) and instruction memory (slave).
// Single outstanding request; the request and its address are held until the valid strobe.
interface ifu_fetch_if #(
  parameter int unsigned IMEM_AW = 32
) ();

  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_valid;
  logic [31:0]        imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, issues one fetch at a time and fills IF/ID with MIPS delay-slot redirects.
// Optional IFU_ADEL_EN: misaligned fetch PCs raise an address-error marker (if_id_exc) instead of a fetch.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IMEM_AW  = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          boj,
  input  logic [31:0]   redirect_pc,
  ifu_fetch_if.master   imem,
  output logic          if_id_valid,
  output logic [31:0]   if_id_instr,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_pc8,
`ifdef IFU_ADEL_EN
  output logic          if_id_exc,
`endif
  output logic [31:0]   fetch_pc
);

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] skid_q, skid_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc8_q, if_id_pc8_d;
`ifdef IFU_ADEL_EN
  logic        if_id_exc_q, if_id_exc_d;
`endif

  logic        id_accept;
  logic        take_redirect;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic [31:0] next_pc;
  logic        req;

  // A branch/jump in ID only counts once ID actually hands it on.
  assign id_accept     = if_id_valid_q & ~stall;
  assign take_redirect = boj & id_accept;
  assign pc_plus4      = fetch_pc_q + 32'd4;
  assign pc_plus8      = fetch_pc_q + 32'd8;

  always_comb begin
    if (take_redirect) begin
      next_pc = redirect_pc;
    end else if (pend_valid_q) begin
      next_pc = pend_pc_q;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    skid_d        = skid_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc8_d   = if_id_pc8_q;
`ifdef IFU_ADEL_EN
    if_id_exc_d   = if_id_exc_q;
`endif
    req           = 1'b0;

    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
      end

      StFetch: begin
        req = 1'b1;
`ifdef IFU_ADEL_EN
        if (fetch_pc_q[1:0] != 2'b00) begin
          // Address error: no memory access, a marked nop takes the fetch slot.
          req = 1'b0;
          if (!stall) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = 32'h0;
            if_id_pc_d    = fetch_pc_q;
            if_id_pc8_d   = pc_plus8;
            if_id_exc_d   = 1'b1;
            fetch_pc_d    = next_pc;
            pend_valid_d  = 1'b0;
          end
        end else
`endif
        if (imem.imem_valid) begin
          if (!stall) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem.imem_rdata;
            if_id_pc_d    = fetch_pc_q;
            if_id_pc8_d   = pc_plus8;
`ifdef IFU_ADEL_EN
            if_id_exc_d   = 1'b0;
`endif
            fetch_pc_d    = next_pc;
            pend_valid_d  = 1'b0;
          end else begin
            skid_d  = imem.imem_rdata;
            state_d = StHold;
          end
        end else begin
          if (!stall) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = 32'h0;
`ifdef IFU_ADEL_EN
            if_id_exc_d   = 1'b0;
`endif
          end
          // The in-flight fetch is the delay slot; remember where to go after it lands.
          if (take_redirect) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = redirect_pc;
          end
        end
      end

      StHold: begin
        if (!stall) begin
          if_id_valid_d = 1'b1;
          if_id_instr_d = skid_q;
          if_id_pc_d    = fetch_pc_q;
          if_id_pc8_d   = pc_plus8;
`ifdef IFU_ADEL_EN
          if_id_exc_d   = 1'b0;
`endif
          fetch_pc_d    = next_pc;
          pend_valid_d  = 1'b0;
          state_d       = StFetch;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= 32'h0;
      skid_q        <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= 32'h0;
      if_id_pc_q    <= 32'h0;
      if_id_pc8_q   <= 32'h0;
`ifdef IFU_ADEL_EN
      if_id_exc_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
      skid_q        <= skid_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc8_q   <= if_id_pc8_d;
`ifdef IFU_ADEL_EN
      if_id_exc_q   <= if_id_exc_d;
`endif
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = IMEM_AW'(fetch_pc_q);
  assign if_id_valid    = if_id_valid_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc8      = if_id_pc8_q;
`ifdef IFU_ADEL_EN
  assign if_id_exc      = if_id_exc_q;
`endif
  assign fetch_pc       = fetch_pc_q;

  // An unanswered request must not move or drop.
  req_held_a: assert property (@(posedge clk) disable iff (!reset_n)
    (imem.imem_req && !imem.imem_valid) |=> (imem.imem_req && $stable(imem.imem_addr)));

  boot_no_req_a: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == StBoot) |-> !imem.imem_req);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: boot, sequential fetch, delay slot, stall skid, latency, wrap, reset.
// Define IFU_ADEL_EN to also exercise the misaligned-fetch address-error path.
module tb_ifu_fetch;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        boj;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc8;
  logic [31:0] fetch_pc;
`ifdef IFU_ADEL_EN
  logic        if_id_exc;
`endif

  int checks;
  int failures;

  ifu_fetch_if #(.IMEM_AW(32)) imem_bus ();

  ifu_fetch #(
    .RESET_PC (32'h0000_3000),
    .IMEM_AW  (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .boj         (boj),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc8   (if_id_pc8),
`ifdef IFU_ADEL_EN
    .if_id_exc   (if_id_exc),
`endif
    .fetch_pc    (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [96:0] ifid_exp(input logic [31:0] pc);
    return {1'b1, mem_word(pc), pc, pc + 32'd8};
  endfunction

  // Zero-latency memory answer for whatever is being requested this cycle.
  task automatic respond();
    imem_bus.imem_valid = imem_bus.imem_req;
    imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; boj = 1'b0; redirect_pc = 32'h0;
    imem_bus.imem_valid = 1'b0; imem_bus.imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h0000_3000) begin
      $display("FAIL reset_fetch_pc: got %h expected %h", fetch_pc, 32'h0000_3000); failures++;
    end
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc8, imem_bus.imem_req} !== 98'h0) begin
      $display("FAIL reset_ifid: got v=%b i=%h pc=%h pc8=%h req=%b expected all zero",
               if_id_valid, if_id_instr, if_id_pc, if_id_pc8, imem_bus.imem_req);
      failures++;
    end
`ifdef IFU_ADEL_EN
    checks++;
    if (if_id_exc !== 1'b0) begin
      $display("FAIL reset_exc: got %b expected 0", if_id_exc); failures++;
    end
`endif
    reset_n = 1'b1;
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      $display("FAIL boot_no_req: got %b expected 0", imem_bus.imem_req); failures++;
    end
  endtask

  task automatic test_sequential();
    @(negedge clk);
    checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 32'h0000_3000}) begin
      $display("FAIL first_req: got req=%b addr=%h expected 1 00003000",
               imem_bus.imem_req, imem_bus.imem_addr);
      failures++;
    end
    respond();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc8} !== ifid_exp(32'h3000 + 32'(4 * k))) begin
        $display("FAIL seq_ifid%0d: got v=%b i=%h pc=%h pc8=%h expected pc %h", k, if_id_valid,
                 if_id_instr, if_id_pc, if_id_pc8, 32'h3000 + 32'(4 * k));
        failures++;
      end
      checks++;
      if (imem_bus.imem_addr !== 32'h3004 + 32'(4 * k)) begin
        $display("FAIL seq_addr%0d: got %h expected %h", k, imem_bus.imem_addr,
                 32'h3004 + 32'(4 * k));
        failures++;
      end
      respond();
    end
  endtask

  // IF/ID holds 0x3004 (the branch); the in-flight 0x3008 is its delay slot.
  task automatic test_branch_delay_slot();
    boj = 1'b1; redirect_pc = 32'h0000_3100;
    @(negedge clk);
    boj = 1'b0;
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc8} !== ifid_exp(32'h3008)) begin
      $display("FAIL delay_slot_ifid: got pc=%h i=%h expected pc 00003008", if_id_pc, if_id_instr);
      failures++;
    end
    checks++;
    if (imem_bus.imem_addr !== 32'h0000_3100) begin
      $display("FAIL branch_target_addr: got %h expected 00003100", imem_bus.imem_addr); failures++;
    end
    respond();
    @(negedge clk);
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc8} !== ifid_exp(32'h3100)) begin
      $display("FAIL target_ifid: got pc=%h i=%h expected pc 00003100", if_id_pc, if_id_instr);
      failures++;
    end
    respond();
  endtask

  task automatic test_stall_skid();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc8, imem_bus.imem_req, fetch_pc} !==
          {ifid_exp(32'h3100), 1'b0, 32'h0000_3104}) begin
        $display("FAIL stall_hold%0d: got pc=%h req=%b fetch_pc=%h expected 00003100 0 00003104",
                 k, if_id_pc, imem_bus.imem_req, fetch_pc);
        failures++;
      end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc8} !== ifid_exp(32'h3104)) begin
      $display("FAIL skid_release: got pc=%h i=%h expected pc 00003104", if_id_pc, if_id_instr);
      failures++;
    end
    checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 32'h0000_3108}) begin
      $display("FAIL post_skid_req: got req=%b addr=%h expected 1 00003108",
               imem_bus.imem_req, imem_bus.imem_addr);
      failures++;
    end
  endtask

  task automatic test_latency_redirect();
    boj = 1'b1; redirect_pc = 32'h0000_4000; imem_bus.imem_valid = 1'b0;
    @(negedge clk);
    boj = 1'b0;
    checks++;
    if ({if_id_valid, if_id_instr} !== 33'h0) begin
      $display("FAIL wait_bubble: got v=%b i=%h expected 0 00000000", if_id_valid, if_id_instr);
      failures++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 32'h0000_3108}) begin
        $display("FAIL wait_stable%0d: got req=%b addr=%h expected 1 00003108", k,
                 imem_bus.imem_req, imem_bus.imem_addr);
        failures++;
      end
      if (k < 2) @(negedge clk);
    end
    respond();
    @(negedge clk);
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc8} !== ifid_exp(32'h3108)) begin
      $display("FAIL late_delay_slot: got pc=%h i=%h expected pc 00003108", if_id_pc, if_id_instr);
      failures++;
    end
    checks++;
    if (imem_bus.imem_addr !== 32'h0000_4000) begin
      $display("FAIL pend_target: got %h expected 00004000", imem_bus.imem_addr); failures++;
    end
    respond();
    @(negedge clk);
    checks++;
    if ({if_id_pc, imem_bus.imem_addr} !== {32'h0000_4000, 32'h0000_4004}) begin
      $display("FAIL pend_cleared: got pc=%h addr=%h expected 00004000 00004004",
               if_id_pc, imem_bus.imem_addr);
      failures++;
    end
  endtask

  task automatic test_pc_wrap();
    boj = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    respond();
    @(negedge clk);
    boj = 1'b0;
    checks++;
    if ({if_id_pc, imem_bus.imem_addr} !== {32'h0000_4004, 32'hFFFF_FFFC}) begin
      $display("FAIL wrap_target: got pc=%h addr=%h expected 00004004 fffffffc",
               if_id_pc, imem_bus.imem_addr);
      failures++;
    end
    respond();
    @(negedge clk);
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc8, imem_bus.imem_addr} !==
        {1'b1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0000}) begin
      $display("FAIL wrap_ifid: got pc=%h pc8=%h addr=%h expected fffffffc 00000004 00000000",
               if_id_pc, if_id_pc8, imem_bus.imem_addr);
      failures++;
    end
  endtask

  task automatic test_async_reset();
    imem_bus.imem_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({imem_bus.imem_req, if_id_valid, fetch_pc} !== {2'b00, 32'h0000_3000}) begin
      $display("FAIL async_reset: got req=%b v=%b fetch_pc=%h expected 0 0 00003000",
               imem_bus.imem_req, if_id_valid, fetch_pc);
      failures++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      $display("FAIL reboot_no_req: got %b expected 0", imem_bus.imem_req); failures++;
    end
    @(negedge clk);
    checks++;
    if ({if_id_valid, if_id_instr, imem_bus.imem_req, imem_bus.imem_addr} !==
        {33'h0, 1'b1, 32'h0000_3000}) begin
      $display("FAIL stray_valid: got v=%b i=%h req=%b addr=%h expected 0 0 1 00003000",
               if_id_valid, if_id_instr, imem_bus.imem_req, imem_bus.imem_addr);
      failures++;
    end
    respond();
    @(negedge clk);
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc8} !== ifid_exp(32'h3000)) begin
      $display("FAIL reboot_fetch: got pc=%h i=%h expected pc 00003000", if_id_pc, if_id_instr);
      failures++;
    end
  endtask

`ifdef IFU_ADEL_EN
  task automatic test_adel();
    boj = 1'b1; redirect_pc = 32'h0000_3002;
    respond();
    @(negedge clk);
    boj = 1'b0; imem_bus.imem_valid = 1'b0;
    checks++;
    if ({if_id_pc, fetch_pc, imem_bus.imem_req} !== {32'h0000_3004, 32'h0000_3002, 1'b0}) begin
      $display("FAIL adel_no_req: got pc=%h fetch_pc=%h req=%b expected 00003004 00003002 0",
               if_id_pc, fetch_pc, imem_bus.imem_req);
      failures++;
    end
    @(negedge clk);
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_exc} !== {1'b1, 32'h0, 32'h0000_3002, 1'b1})
    begin
      $display("FAIL adel_ifid: got v=%b i=%h pc=%h exc=%b expected 1 00000000 00003002 1",
               if_id_valid, if_id_instr, if_id_pc, if_id_exc);
      failures++;
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_branch_delay_slot();
    test_stall_skid();
    test_latency_redirect();
    test_pc_wrap();
    test_async_reset();
`ifdef IFU_ADEL_EN
    test_adel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
